// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, header field positions, coordinate
// width and the XY routing function used by the switch allocator.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned COORD_W   = 2;
  // Header fields counted down from the flit MSB: dest_x occupies the top
  // COORD_W bits, dest_y the next COORD_W bits.
  localparam int unsigned HDR_X_TOP = 1;
  localparam int unsigned HDR_Y_TOP = 3;

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_E = 2'd1,
    PORT_W = 2'd2,
    PORT_L = 2'd3
  } port_e;

  typedef struct packed {
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } dest_t;

  // Dimension-ordered routing: resolve X first, then Y, else local.
  function automatic port_e xy_route(input dest_t dest,
                                     input logic [COORD_W-1:0] my_x,
                                     input logic [COORD_W-1:0] my_y);
    if (dest.dest_x > my_x)      return PORT_E;
    else if (dest.dest_x < my_x) return PORT_W;
    else if (dest.dest_y != my_y) return PORT_N;
    else                         return PORT_L;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter for one output port.
// Ports: clk, rst (sync, active-high), req[3:0] requests (N,E,W,L order),
//        pressure[3:0] per-requester occupancy, gnt_c[3:0] one-hot grant
//        (combinational). The 2-bit pointer moves past the winner on a grant.
// Build option: PRESSURE_PRIO_EN restricts the candidates to the requesters
//        with the highest pressure before the round-robin pick.
module rr_arb4 #(
  parameter int unsigned PW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0][PW-1:0]  pressure,
  output logic [3:0]          gnt_c
);

  logic [1:0] ptr_q;
  logic [3:0] cand;
  logic [1:0] gnt_idx;
  logic       gnt_any;
  logic [1:0] idx;

`ifdef PRESSURE_PRIO_EN
  logic [PW-1:0] max_p;

  // Keep only the requesters sharing the largest pressure.
  always_comb begin
    max_p = '0;
    cand  = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (pressure[i] > max_p)) max_p = pressure[i];
    end
    for (int i = 0; i < 4; i++) begin
      cand[i] = req[i] && (pressure[i] == max_p);
    end
  end
`else
  logic unused_pressure;
  assign unused_pressure = ^pressure;
  assign cand = req;
`endif

  // First candidate at or after the pointer, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_any && cand[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_c = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // Pointer state.
  always_ff @(posedge clk) begin
    if (rst)          ptr_q <= '0;
    else if (gnt_any) ptr_q <= gnt_idx + 2'd1;
  end

endmodule

// File: rtl/switch_alloc_21.sv
// 4-port (N,E,W,L) XY-routed switch allocator with registered outputs.
// Each valid input head flit requests one output; each output has its own
// rr_arb4 and a one-flit output register. A grant pops the input FIFO
// (fifo_ready_X, combinational) and loads the flit at the same edge.
// Ports: fifo_clk, rst (sync, active-high);
//        per port X in {N,E,W,L}: X_data_in, X_valid_in, X_pressure_in,
//        X_full_in (inputs); fifo_ready_X, X_data_out, X_valid_out (outputs).
// Build option: PRESSURE_PRIO_EN enables pressure-first arbitration.
module switch_alloc_21
  import noc_pkg::*;
#(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MY_X     = 2,
  parameter int unsigned MY_Y     = 1
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                N_valid_in,
  input  logic                E_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  input  logic [WIDTH:0]      N_pressure_in,
  input  logic [WIDTH:0]      E_pressure_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,
  input  logic                N_full_in,
  input  logic                E_full_in,
  input  logic                W_full_in,
  input  logic                L_full_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_E,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] N_data_out,
  output logic [DATASIZE-1:0] E_data_out,
  output logic [DATASIZE-1:0] W_data_out,
  output logic [DATASIZE-1:0] L_data_out,
  output logic                N_valid_out,
  output logic                E_valid_out,
  output logic                W_valid_out,
  output logic                L_valid_out
);

  localparam int unsigned PW = WIDTH + 1;

  logic [3:0][DATASIZE-1:0] din_c;
  logic [3:0]               vin_c;
  logic [3:0]               full_c;
  logic [3:0][PW-1:0]       pres_c;

  port_e                    route_c [4];
  logic [3:0]               free_c;
  logic [3:0][3:0]          req_c;   // [output][input]
  logic [3:0][3:0]          gnt_c;   // [output][input]
  logic [3:0]               pop_c;
  logic [3:0][DATASIZE-1:0] mux_c;

  logic [3:0][DATASIZE-1:0] dout_q;
  logic [3:0]               vout_q;

  assign din_c  = {L_data_in, W_data_in, E_data_in, N_data_in};
  assign vin_c  = {L_valid_in, W_valid_in, E_valid_in, N_valid_in};
  assign full_c = {L_full_in, W_full_in, E_full_in, N_full_in};
  assign pres_c = {L_pressure_in, W_pressure_in, E_pressure_in, N_pressure_in};

  // Route each head flit from its header coordinates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      route_c[i] = xy_route({din_c[i][DATASIZE-HDR_X_TOP -: COORD_W],
                             din_c[i][DATASIZE-HDR_Y_TOP -: COORD_W]},
                            COORD_W'(MY_X), COORD_W'(MY_Y));
    end
  end

  // An output can take a flit when empty or draining this cycle; reset
  // masks all requests so nothing pops during reset.
  always_comb begin
    free_c = ~vout_q | ~full_c;
    req_c  = '0;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        req_c[o][i] = vin_c[i] & free_c[o] & ~rst &
                      (2'(route_c[i]) == 2'(o));
      end
    end
  end

  for (genvar o = 0; o < 4; o++) begin : g_arb
    rr_arb4 #(.PW(PW)) u_arb (
      .clk      (fifo_clk),
      .rst      (rst),
      .req      (req_c[o]),
      .pressure (pres_c),
      .gnt_c    (gnt_c[o])
    );
  end

  // Pops and per-output data select from the one-hot grants.
  always_comb begin
    pop_c = '0;
    mux_c = '0;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        pop_c[i] = pop_c[i] | gnt_c[o][i];
        if (gnt_c[o][i]) mux_c[o] = din_c[i];
      end
    end
  end

  // Output registers: load on grant, clear valid when drained, hold if stalled.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      dout_q <= '0;
      vout_q <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        if (|gnt_c[o]) begin
          dout_q[o] <= mux_c[o];
          vout_q[o] <= 1'b1;
        end else if (!full_c[o]) begin
          vout_q[o] <= 1'b0;
        end
      end
    end
  end

  assign fifo_ready_N = pop_c[PORT_N];
  assign fifo_ready_E = pop_c[PORT_E];
  assign fifo_ready_W = pop_c[PORT_W];
  assign fifo_ready_L = pop_c[PORT_L];

  assign N_data_out  = dout_q[PORT_N];
  assign E_data_out  = dout_q[PORT_E];
  assign W_data_out  = dout_q[PORT_W];
  assign L_data_out  = dout_q[PORT_L];
  assign N_valid_out = vout_q[PORT_N];
  assign E_valid_out = vout_q[PORT_E];
  assign W_valid_out = vout_q[PORT_W];
  assign L_valid_out = vout_q[PORT_L];

endmodule

// File: tb/tb_switch_alloc_21.sv
// Directed bench for switch_alloc_21 (MY_X=2, MY_Y=1): a vector table for
// routing and parallel transfers, plus sequences for reset, contention,
// backpressure and pressure-priority arbitration. Port vectors use the
// index order N=0, E=1, W=2, L=3.
module tb_switch_alloc_21;

  localparam int unsigned DS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [3:0]           vin;
  logic [3:0]           full;
  logic [3:0][DS-1:0]   din;
  logic [3:0][3:0]      pres;

  logic [DS-1:0] n_do, e_do, w_do, l_do;
  logic n_vo, e_vo, w_vo, l_vo;
  logic n_rdy, e_rdy, w_rdy, l_rdy;

  logic [3:0][DS-1:0] dout;
  logic [3:0]         vout;
  logic [3:0]         rdy;
  assign dout = {l_do, w_do, e_do, n_do};
  assign vout = {l_vo, w_vo, e_vo, n_vo};
  assign rdy  = {l_rdy, w_rdy, e_rdy, n_rdy};

  switch_alloc_21 dut (
    .fifo_clk      (clk),
    .rst           (rst),
    .N_data_in     (din[0]),
    .E_data_in     (din[1]),
    .W_data_in     (din[2]),
    .L_data_in     (din[3]),
    .N_valid_in    (vin[0]),
    .E_valid_in    (vin[1]),
    .W_valid_in    (vin[2]),
    .L_valid_in    (vin[3]),
    .N_pressure_in (pres[0]),
    .E_pressure_in (pres[1]),
    .W_pressure_in (pres[2]),
    .L_pressure_in (pres[3]),
    .N_full_in     (full[0]),
    .E_full_in     (full[1]),
    .W_full_in     (full[2]),
    .L_full_in     (full[3]),
    .fifo_ready_N  (n_rdy),
    .fifo_ready_E  (e_rdy),
    .fifo_ready_W  (w_rdy),
    .fifo_ready_L  (l_rdy),
    .N_data_out    (n_do),
    .E_data_out    (e_do),
    .W_data_out    (w_do),
    .L_data_out    (l_do),
    .N_valid_out   (n_vo),
    .E_valid_out   (e_vo),
    .W_valid_out   (w_vo),
    .L_valid_out   (l_vo)
  );

  typedef struct {
    logic [3:0]         valid;
    logic [3:0][DS-1:0] data;
    logic [3:0]         full;
    logic [3:0]         exp_ready;
    logic [3:0]         exp_vout;
    logic [3:0][DS-1:0] exp_dout;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DS-1:0] flit(input logic [1:0] dx,
                                         input logic [1:0] dy, input int tag);
    return {dx, dy, 36'(tag)};
  endfunction

  // Two reset cycles with every input valid: no pops, outputs cleared.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    vin  = 4'hF;
    full = '0;
    pres = '0;
    for (int i = 0; i < 4; i++) din[i] = flit(2'd3, 2'd1, 'h50 + i);
    repeat (2) begin
      #1 check("rst_ready", 64'(rdy), 64'h0);
      @(posedge clk);
      #1 check("rst_vout", 64'(vout), 64'h0);
      check("rst_dout_zero", 64'(|dout), 64'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    vin = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt [4];
    int exp_cnt [4];
    int order [3];
    int idx;
    logic [3:0] snap;
    logic [3:0] exp_r1, exp_r2;
    logic [DS-1:0] exp_d1, exp_d2;

    rst = 1'b1; vin = '0; full = '0; din = '0; pres = '0;
    do_reset();

    // Routing and parallel-transfer vectors (applied back to back).
    for (int v = 0; v < NVEC; v++) begin
      vecs[v].valid = '0; vecs[v].data = '0; vecs[v].full = '0;
      vecs[v].exp_ready = '0; vecs[v].exp_vout = '0; vecs[v].exp_dout = '0;
    end
    // L -> dest (3,1) -> E
    vecs[0].valid = 4'b1000; vecs[0].data[3] = flit(2'd3, 2'd1, 1);
    vecs[0].exp_ready = 4'b1000; vecs[0].exp_vout = 4'b0010;
    vecs[0].exp_dout[1] = flit(2'd3, 2'd1, 1);
    // L -> dest (0,1) -> W; E drains
    vecs[1].valid = 4'b1000; vecs[1].data[3] = flit(2'd0, 2'd1, 2);
    vecs[1].exp_ready = 4'b1000; vecs[1].exp_vout = 4'b0100;
    vecs[1].exp_dout[2] = flit(2'd0, 2'd1, 2);
    // L -> dest (2,0) -> N
    vecs[2].valid = 4'b1000; vecs[2].data[3] = flit(2'd2, 2'd0, 3);
    vecs[2].exp_ready = 4'b1000; vecs[2].exp_vout = 4'b0001;
    vecs[2].exp_dout[0] = flit(2'd2, 2'd0, 3);
    // L -> dest (2,1) -> L (U-turn)
    vecs[3].valid = 4'b1000; vecs[3].data[3] = flit(2'd2, 2'd1, 4);
    vecs[3].exp_ready = 4'b1000; vecs[3].exp_vout = 4'b1000;
    vecs[3].exp_dout[3] = flit(2'd2, 2'd1, 4);
    // Parallel: N->L, E->W, W->E, L->N
    vecs[4].valid = 4'b1111;
    vecs[4].data[0] = flit(2'd2, 2'd1, 5);
    vecs[4].data[1] = flit(2'd0, 2'd1, 6);
    vecs[4].data[2] = flit(2'd3, 2'd1, 7);
    vecs[4].data[3] = flit(2'd2, 2'd0, 8);
    vecs[4].exp_ready = 4'b1111; vecs[4].exp_vout = 4'b1111;
    vecs[4].exp_dout[0] = flit(2'd2, 2'd0, 8);
    vecs[4].exp_dout[1] = flit(2'd3, 2'd1, 7);
    vecs[4].exp_dout[2] = flit(2'd0, 2'd1, 6);
    vecs[4].exp_dout[3] = flit(2'd2, 2'd1, 5);
    // Idle: everything drains
    vecs[5].exp_ready = 4'b0000; vecs[5].exp_vout = 4'b0000;
    // N -> dest (2,3) -> N (U-turn), E -> dest (1,3) -> W
    vecs[6].valid = 4'b0011;
    vecs[6].data[0] = flit(2'd2, 2'd3, 9);
    vecs[6].data[1] = flit(2'd1, 2'd3, 10);
    vecs[6].exp_ready = 4'b0011; vecs[6].exp_vout = 4'b0101;
    vecs[6].exp_dout[0] = flit(2'd2, 2'd3, 9);
    vecs[6].exp_dout[2] = flit(2'd1, 2'd3, 10);

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      vin = vecs[v].valid; din = vecs[v].data; full = vecs[v].full;
      #1 check($sformatf("vec%0d_ready", v), 64'(rdy), 64'(vecs[v].exp_ready));
      @(posedge clk);
      #1 check($sformatf("vec%0d_vout", v), 64'(vout), 64'(vecs[v].exp_vout));
      for (int o = 0; o < 4; o++) begin
        if (vecs[v].exp_vout[o])
          check($sformatf("vec%0d_dout%0d", v, o), 64'(dout[o]),
                64'(vecs[v].exp_dout[o]));
      end
    end

    // Contention: N, W, L all to E -> grants N, W, L, N, W, L.
    do_reset();
    order = '{0, 2, 3};
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; exp_cnt[i] = 0; end
    for (int c = 0; c < 6; c++) begin
      idx = order[c % 3];
      @(negedge clk);
      vin = 4'b1101; full = '0;
      for (int i = 0; i < 4; i++) din[i] = flit(2'd3, 2'd1, i * 16 + cnt[i]);
      #1 check($sformatf("cont%0d_ready", c), 64'(rdy), 64'(4'b0001 << idx));
      snap = rdy;
      @(posedge clk);
      for (int i = 0; i < 4; i++) if (snap[i]) cnt[i]++;
      #1 check($sformatf("cont%0d_evalid", c), 64'(e_vo), 64'h1);
      check($sformatf("cont%0d_edata", c), 64'(e_do),
            64'(flit(2'd3, 2'd1, idx * 16 + exp_cnt[idx])));
      exp_cnt[idx]++;
    end
    check("cont_share_n", 64'(cnt[0]), 64'd2);
    check("cont_share_w", 64'(cnt[2]), 64'd2);
    check("cont_share_l", 64'(cnt[3]), 64'd2);

    // Reset while E still holds a flit and inputs are valid.
    do_reset();

    // Backpressure on E for 5 cycles, then release.
    @(negedge clk);
    vin = 4'b0100; full = '0; din[2] = flit(2'd3, 2'd1, 'hA0);
    #1 check("bp_first_ready", 64'(rdy), 64'(4'b0100));
    @(posedge clk);
    #1 check("bp_first_data", 64'(e_do), 64'(flit(2'd3, 2'd1, 'hA0)));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      din[2] = flit(2'd3, 2'd1, 'hA1); full = 4'b0010;
      #1 check($sformatf("bp%0d_ready", c), 64'(rdy), 64'h0);
      @(posedge clk);
      #1 check($sformatf("bp%0d_evalid", c), 64'(e_vo), 64'h1);
      check($sformatf("bp%0d_edata", c), 64'(e_do),
            64'(flit(2'd3, 2'd1, 'hA0)));
    end
    @(negedge clk);
    full = '0;
    #1 check("bp_release_ready", 64'(rdy), 64'(4'b0100));
    @(posedge clk);
    #1 check("bp_release_data", 64'(e_do), 64'(flit(2'd3, 2'd1, 'hA1)));
    @(negedge clk);
    vin = '0;
    @(posedge clk);
    #1 check("bp_drain_evalid", 64'(e_vo), 64'h0);

    // Pressure priority: move E pointer to 1, then N(p6) vs W(p2).
    do_reset();
    @(negedge clk);
    vin = 4'b0001; din[0] = flit(2'd3, 2'd1, 'hB0);
    #1 check("pr_setup_ready", 64'(rdy), 64'(4'b0001));
    @(posedge clk);
    @(negedge clk);
    vin = '0;
    @(posedge clk);
`ifdef PRESSURE_PRIO_EN
    exp_r1 = 4'b0001; exp_d1 = flit(2'd3, 2'd1, 'hB1);
    exp_r2 = 4'b0100; exp_d2 = flit(2'd3, 2'd1, 'hC0);
`else
    exp_r1 = 4'b0100; exp_d1 = flit(2'd3, 2'd1, 'hC0);
    exp_r2 = 4'b0001; exp_d2 = flit(2'd3, 2'd1, 'hB1);
`endif
    @(negedge clk);
    vin = 4'b0101;
    din[0] = flit(2'd3, 2'd1, 'hB1); din[2] = flit(2'd3, 2'd1, 'hC0);
    pres[0] = 4'd6; pres[2] = 4'd2;
    #1 check("pr_high_ready", 64'(rdy), 64'(exp_r1));
    @(posedge clk);
    #1 check("pr_high_data", 64'(e_do), 64'(exp_d1));
    @(negedge clk);
    pres[0] = 4'd4; pres[2] = 4'd4;
    #1 check("pr_equal_ready", 64'(rdy), 64'(exp_r2));
    @(posedge clk);
    #1 check("pr_equal_data", 64'(e_do), 64'(exp_d2));
    @(negedge clk);
    vin = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_alloc_21.md
SWITCH_ALLOC_21 -- requirements
Module: switch_alloc_21

Interface
REQ-001 Parameter DATASIZE, default 40, SHALL set the flit width in bits.
REQ-002 Parameter WIDTH, default 3, SHALL size the pressure inputs at WIDTH+1 bits.
REQ-003 Parameter MY_X, default 2, SHALL set the router X coordinate (2 bits).
REQ-004 Parameter MY_Y, default 1, SHALL set the router Y coordinate (2 bits).
REQ-005 fifo_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-007 X_data_in  in  DATASIZE  SHALL carry the head flit of input FIFO X (X in N,E,W,L).
REQ-008 X_valid_in  in  1  SHALL mean input FIFO X is non-empty and X_data_in is valid.
REQ-009 X_pressure_in  in  WIDTH+1  SHALL carry the occupancy of input FIFO X.
REQ-010 fifo_ready_X  out  1  SHALL pop input FIFO X in the cycle it is high.
REQ-011 X_data_out  out  DATASIZE  SHALL be the registered flit for output port X.
REQ-012 X_valid_out  out  1  SHALL mean X_data_out holds a flit.
REQ-013 X_full_in  in  1  SHALL mean the downstream receiver on port X cannot accept this cycle.

Function
REQ-014 Route: dest_x = data[DATASIZE-1:DATASIZE-2], dest_y = data[DATASIZE-3:DATASIZE-4]; dest_x>MY_X -> E, dest_x<MY_X -> W, else dest_y!=MY_Y -> N, else L.
REQ-015 Each valid input SHALL request exactly one output per cycle, computed combinationally from its head flit.
REQ-016 Each output SHALL have an independent 4-way arbiter with a 2-bit round-robin pointer (order N=0,E=1,W=2,L=3); the pointer grants the first requester at or after the pointer.
REQ-017 On a grant, that output's pointer SHALL advance to (granted index + 1) mod 4; with no grant it SHALL hold.
REQ-018 An output slot is free when X_valid_out=0 or X_full_in=0; a grant SHALL be issued only to a free output.
REQ-019 fifo_ready_X SHALL be high, combinationally, exactly when input X holds a grant; it SHALL never be high with X_valid_in=0.
REQ-020 A granted flit SHALL be loaded into the output register at the same edge; latency pop-to-X_valid_out SHALL be 1 cycle.
REQ-021 When an output drains (valid & !full) with no new grant, X_valid_out SHALL fall next cycle; with a new grant it SHALL stay high (1 flit/cycle/output throughput).
REQ-022 When X_valid_out=1 and X_full_in=1, X_data_out and X_valid_out SHALL hold; no grant to X.
REQ-023 Different outputs SHALL be granted in the same cycle independently (up to 4 simultaneous transfers).
REQ-024 U-turn traffic (input X routed to output X) SHALL be forwarded like any other.

Reset
REQ-025 While rst=1: all X_valid_out=0, X_data_out=0, pointers=0, fifo_ready_X=0.
REQ-026 Reset mid-transfer SHALL discard registered flits; no pop SHALL occur in the reset cycle.

Configuration
REQ-027 With PRESSURE_PRIO_EN defined, each arbiter SHALL grant the requester with the largest X_pressure_in, ties broken by the round-robin pointer order.
REQ-028 Without PRESSURE_PRIO_EN, X_pressure_in SHALL be ignored and arbitration SHALL be pure round-robin.

Structure
REQ-029 Port indices (N,E,W,L), header field offsets and coordinate width SHALL live in a shared package noc_pkg.
REQ-030 The per-output arbiter SHALL be one sub-module, rr_arb4, instantiated four times.

Verification
REQ-031 Reset: rst=1 two cycles with all inputs valid -> all fifo_ready_X=0, all X_valid_out=0, data 0.
REQ-032 Routing: L flit dest (3,1) -> E_valid_out next cycle; dest (0,1) -> W; dest (2,0) -> N; dest (2,1) -> L.
REQ-033 Contention: N,W,L all target E continuously, E_full_in=0 -> E grants N,W,L,N,... one per cycle, each input gets 1/3.
REQ-034 Backpressure: E_full_in=1 with E_valid_out=1 for 5 cycles -> E_data_out stable, no pop toward E; release -> transfer resumes next cycle, no flit lost or duplicated.
REQ-035 Parallel: N->L, E->W, W->E, L->N simultaneously -> all four fifo_ready high same cycle, four outputs valid next cycle.
REQ-036 PRESSURE_PRIO_EN: N pressure 6, W pressure 2, both to E -> N granted; equal pressures -> round-robin order.
